mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single-ported unified instruction/data memory between the core's fetch stage and its load/store stage. It accepts one word-aligned fetch request and one byte/half/word load or store request, serialises them onto one synchronous RAM port, and steers store bytes onto write strobes. It sits between the `riscv_i` core and the memory array.

## Interface
- `BASE` — default 32'h8000_0000 — byte address mapped to word 0 of the RAM.
- `DEPTH_LOG2` — default 12 — RAM depth is 2**DEPTH_LOG2 words (4096).
- `clk  in  1` — clock; all state changes on the rising edge.
- `reset  in  1` — asynchronous, active-high reset.
- `i_req  in  1` — fetch request; held until `i_ack`.
- `i_addr  in  32` — fetch byte address.
- `i_ack  out  1` — one-cycle pulse; `i_rdata`/`i_err` are valid in the same cycle.
- `i_rdata  out  32` — fetched word.
- `i_err  out  1` — address is out of range or not word-aligned.
- `d_req  in  1` — load/store request; held until `d_ack`.
- `d_we  in  1` — 1 = store, 0 = load.
- `d_size  in  2` — 00 byte, 01 half, 10 word (fun3[1:0]); 11 is illegal.
- `d_addr  in  32` — byte address.
- `d_wdata  in  32` — store data, right-justified (value in bits [7:0] / [15:0] / [31:0]).
- `d_ack  out  1` — one-cycle completion pulse.
- `d_rdata  out  32` — raw aligned word containing the addressed bytes. The core performs sign or zero extension.
- `d_err  out  1` — misaligned access, illegal size, or out of range.
- `mem_en  out  1` — RAM access strobe.
- `mem_we  out  4` — per-byte write enables.
- `mem_addr  out  DEPTH_LOG2` — word index.
- `mem_wdata  out  32` — lane-steered write data.
- `mem_rdata  in  32` — RAM read data, valid one cycle after `mem_en`.

## Operation
- The FSM has three states: IDLE, ACCESS, RESP.
- **IDLE**
  - If neither request is asserted, stay in IDLE.
  - Otherwise pick a winner, register the winner's address, strobes and data, and go to ACCESS.
  - Error check at grant time: address < BASE; index = (addr−BASE)>>2 ≥ 2**DEPTH_LOG2; fetch addr[1:0] ≠ 0; half with addr[0] = 1; word with addr[1:0] ≠ 0; `d_size` = 11.
  - An erroring request goes to RESP directly. It produces no `mem_en` and no write; its ack carries err = 1 and rdata = 0.
- **ACCESS**
  - `mem_en` = 1, with `mem_we` and `mem_wdata` driven from the registered values, for exactly one cycle.
  - Next state is RESP.
- **RESP**
  - Pulse the winner's ack.
  - The winner's rdata is `mem_rdata` captured this cycle. For stores, rdata is the RAM's pre-write contents and is don't-care to the consumer.
  - Next state is IDLE.
- **Lane steering**
  - Byte: `mem_we` = 1 << addr[1:0]; the byte is replicated to all four lanes.
  - Half: `mem_we` = 0011 or 1100 by addr[1]; the half is replicated to both halves.
  - Word: `mem_we` = 1111.
  - Loads have `mem_we` = 0000.
- **Arbitration without the macro:** fixed priority; the data port wins when both are requesting.
- Requests arriving outside IDLE wait. No request is dropped.
- Deasserting a request before its ack violates the protocol. The arbiter still completes the granted access and pulses the ack.

## Timing
- Reset values: all acks 0, `i_err`/`d_err` 0, rdata 0, `mem_en` 0, `mem_we` 0000, `mem_addr` 0, `mem_wdata` 0, state IDLE, last-grant = fetch.
- Legal access: request seen in IDLE at edge N → `mem_en` high in cycle N+1 → ack in cycle N+2. Latency is 2 cycles.
- Error access: ack in cycle N+1.
- Throughput: one access per 3 cycles. A request held high through its ack cycle is re-arbitrated in the following IDLE cycle.
- Reset asserted mid-operation:
  - All state clears immediately; no ack is issued.
  - A store whose `mem_en` edge has already occurred stays written.
  - Otherwise no write occurs.
- Acks are never asserted for both ports in the same cycle.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration. On contention, grant the port that did not win the last grant. Last-grant resets to fetch, so the first contention goes to data.
- `MEM_ARB_RR_EN` undefined: fixed data priority. The last-grant register is absent.

## Structure
- Package `riscv_pkg` holds:
  - the size encodings SIZE_B/SIZE_H/SIZE_W;
  - the `arb_state_t` enum (IDLE, ACCESS, RESP);
  - the `MEM_BASE` constant.
- Sub-module `mem_lane_steer`: combinational (size, addr[1:0], wdata) → (we[3:0], wdata_steered, misaligned). It is instantiated once on the granted request.

## Test plan
- Fetch only, `i_addr` = 0x8000_0004, RAM word 1 = 0x00500093 → `mem_addr` = 1 at N+1; `i_ack` at N+2 with `i_rdata` = 0x00500093, `i_err` = 0.
- SB of 0xAB at 0x8000_0013 → `mem_we` = 1000, `mem_wdata` = 0xABABABAB, `mem_addr` = 4. A following LW at 0x8000_0010 returns 0xAB in byte 3 with the other bytes unchanged.
- Both `i_req` and `d_req` asserted in the same cycle, held for 4 accesses:
  - without the macro, the grant order is D, D, D, D;
  - with `MEM_ARB_RR_EN`, the grant order is D, I, D, I.
- Error requests produce an ack at N+1 with err = 1, no `mem_en` and rdata = 0:
  - SH at 0x8000_0001;
  - LW at 0x8000_4000 (index 4096);
  - fetch at 0x7FFF_FFFC.
- Reset pulsed in the ACCESS cycle of a store → no ack. After reset, all outputs are zero and state is IDLE. The next request completes with normal latency.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings, FSM state type and memory map constants for the core's memory path.
package riscv_pkg;

    localparam logic [1:0]  SIZE_B   = 2'b00;
    localparam logic [1:0]  SIZE_H   = 2'b01;
    localparam logic [1:0]  SIZE_W   = 2'b10;
    localparam logic [31:0] MEM_BASE = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // Out of range when below the base or when the word index overflows the array.
    function automatic logic addr_oob(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] off,
                                      input int          depth_log2);
        logic below;
        logic over;
        below = (addr < base);
        over  = ((off >> (depth_log2 + 2)) != 32'd0);
        return below | over;
    endfunction

endpackage

// File: rtl/mem_lane_steer.sv
// Byte-lane steering: turns (size, low address bits, right-justified data) into
// RAM write strobes and replicated write data, flagging misaligned or illegal sizes.
module mem_lane_steer
    import riscv_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  we,
    output logic [31:0] wdata_steered,
    output logic        misaligned
);

    // Strobe and data replication per access size; size 11 reports as misaligned.
    always_comb begin
        we            = 4'b0000;
        wdata_steered = wdata;
        misaligned    = 1'b0;
        case (size)
            SIZE_B: begin
                we            = 4'b0001 << addr_lo;
                wdata_steered = {4{wdata[7:0]}};
                misaligned    = 1'b0;
            end
            SIZE_H: begin
                if (addr_lo[1]) begin
                    we = 4'b1100;
                end else begin
                    we = 4'b0011;
                end
                wdata_steered = {2{wdata[15:0]}};
                misaligned    = addr_lo[0];
            end
            SIZE_W: begin
                we            = 4'b1111;
                wdata_steered = wdata;
                misaligned    = (addr_lo != 2'b00);
            end
            default: begin
                we            = 4'b0000;
                wdata_steered = wdata;
                misaligned    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch / load-store arbiter onto one synchronous RAM port (IDLE -> ACCESS -> RESP).
// Define MEM_ARB_RR_EN for round-robin on contention; otherwise the data port always wins.
module mem_arbiter
    import riscv_pkg::*;
#(
    parameter logic [31:0] BASE       = MEM_BASE,
    parameter int          DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [31:0]           i_addr,
    output logic                  i_ack,
    output logic [31:0]           i_rdata,
    output logic                  i_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [1:0]            d_size,
    input  logic [31:0]           d_addr,
    input  logic [31:0]           d_wdata,
    output logic                  d_ack,
    output logic [31:0]           d_rdata,
    output logic                  d_err,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    arb_state_t            state_q, state_d;
    logic                  gnt_data_q, gnt_data_d;
    logic                  i_ack_q, i_ack_d;
    logic                  d_ack_q, d_ack_d;
    logic                  i_err_q, i_err_d;
    logic                  d_err_q, d_err_d;
    logic                  mem_en_q, mem_en_d;
    logic [3:0]            mem_we_q, mem_we_d;
    logic [DEPTH_LOG2-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;

    logic                  any_req_s;
    logic                  take_data_s;
    logic                  sel_store_s;
    logic [31:0]           sel_addr_s;
    logic [1:0]            sel_size_s;
    logic [31:0]           sel_wdata_s;
    logic [31:0]           off_s;
    logic                  req_err_s;
    logic [3:0]            steer_we_s;
    logic [31:0]           steer_wdata_s;
    logic                  steer_mis_s;

`ifdef MEM_ARB_RR_EN
    logic                  last_data_q, last_data_d;
`endif

    // Winner selection among the current requests.
    always_comb begin
        any_req_s = i_req | d_req;
`ifdef MEM_ARB_RR_EN
        take_data_s = d_req & (~i_req | ~last_data_q);
`else
        take_data_s = d_req;
`endif
        if (take_data_s) begin
            sel_addr_s  = d_addr;
            sel_size_s  = d_size;
            sel_wdata_s = d_wdata;
            sel_store_s = d_we;
        end else begin
            sel_addr_s  = i_addr;
            sel_size_s  = SIZE_W;
            sel_wdata_s = 32'd0;
            sel_store_s = 1'b0;
        end
    end

    mem_lane_steer u_steer (
        .size          (sel_size_s),
        .addr_lo       (sel_addr_s[1:0]),
        .wdata         (sel_wdata_s),
        .we            (steer_we_s),
        .wdata_steered (steer_wdata_s),
        .misaligned    (steer_mis_s)
    );

    // Grant-time error check on the winner's address and size.
    always_comb begin
        off_s     = sel_addr_s - BASE;
        req_err_s = steer_mis_s | addr_oob(sel_addr_s, BASE, off_s, DEPTH_LOG2);
    end

    // State register plus all registered outputs and grant bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_data_q  <= 1'b0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_err_q     <= 1'b0;
            d_err_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
`ifdef MEM_ARB_RR_EN
            last_data_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_data_q  <= gnt_data_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            i_err_q     <= i_err_d;
            d_err_q     <= d_err_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef MEM_ARB_RR_EN
            last_data_q <= last_data_d;
`endif
        end
    end

    // Next-state logic; erroring requests skip the RAM cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_req_s && req_err_s) begin
                    state_d = RESP;
                end else if (any_req_s) begin
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; acks are raised on entry to RESP.
    always_comb begin
        gnt_data_d  = gnt_data_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        i_err_d     = 1'b0;
        d_err_d     = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 4'b0000;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef MEM_ARB_RR_EN
        last_data_d = last_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req_s) begin
                    gnt_data_d = take_data_s;
`ifdef MEM_ARB_RR_EN
                    last_data_d = take_data_s;
`endif
                    if (req_err_s) begin
                        i_ack_d = ~take_data_s;
                        d_ack_d = take_data_s;
                        i_err_d = ~take_data_s;
                        d_err_d = take_data_s;
                    end else begin
                        mem_en_d    = 1'b1;
                        mem_we_d    = sel_store_s ? steer_we_s : 4'b0000;
                        mem_addr_d  = off_s[DEPTH_LOG2+1:2];
                        mem_wdata_d = steer_wdata_s;
                    end
                end else begin
                    gnt_data_d = gnt_data_q;
                end
            end
            ACCESS: begin
                i_ack_d = ~gnt_data_q;
                d_ack_d = gnt_data_q;
            end
            RESP: begin
                mem_en_d = 1'b0;
            end
            default: begin
                mem_en_d = 1'b0;
            end
        endcase
    end

    // Read data is the RAM output during a successful ack, zero otherwise.
    always_comb begin
        if (i_ack_q && !i_err_q) begin
            i_rdata = mem_rdata;
        end else begin
            i_rdata = 32'd0;
        end
        if (d_ack_q && !d_err_q) begin
            d_rdata = mem_rdata;
        end else begin
            d_rdata = 32'd0;
        end
    end

    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign i_err     = i_err_q;
    assign d_err     = d_err_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter with a behavioural synchronous RAM.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] ram [0:4095];

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .i_err     (i_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_size    (d_size),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= ram[mem_addr];
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    typedef struct {
        logic        fetch;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic [3:0]  exp_we;
        logic [11:0] exp_maddr;
        logic [31:0] exp_wd;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " ctl"}, {26'd0, i_ack, d_ack, i_err, d_err, mem_en, |mem_we}, 32'd0);
        check({tag, " i_rdata"}, i_rdata, 32'd0);
        check({tag, " d_rdata"}, d_rdata, 32'd0);
        check({tag, " mem_addr"}, {20'd0, mem_addr}, 32'd0);
        check({tag, " mem_wdata"}, mem_wdata, 32'd0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          en_cyc;
        int          ack_cyc;
        logic [3:0]  we_seen;
        logic [11:0] addr_seen;
        logic [31:0] wd_seen;
        logic [31:0] rd_seen;
        logic        err_seen;
        logic        wrong_ack;
        string       nm;
        en_cyc = -1; ack_cyc = -1; we_seen = 4'd0; addr_seen = 12'd0;
        wd_seen = 32'd0; rd_seen = 32'd0; err_seen = 1'b0; wrong_ack = 1'b0;
        nm = $sformatf("v%0d", idx);
        @(negedge clk);
        if (v.fetch) begin
            i_req = 1'b1; i_addr = v.addr;
        end else begin
            d_req = 1'b1; d_we = v.we; d_size = v.size; d_addr = v.addr; d_wdata = v.wdata;
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (mem_en && en_cyc < 0) begin
                en_cyc = k; we_seen = mem_we; addr_seen = mem_addr; wd_seen = mem_wdata;
            end
            if (v.fetch ? d_ack : i_ack) wrong_ack = 1'b1;
            if (v.fetch ? i_ack : d_ack) begin
                ack_cyc  = k;
                rd_seen  = v.fetch ? i_rdata : d_rdata;
                err_seen = v.fetch ? i_err : d_err;
                break;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        check({nm, " ack_cycle"}, ack_cyc, v.exp_err ? 32'd1 : 32'd2);
        check({nm, " other_ack"}, {31'd0, wrong_ack}, 32'd0);
        check({nm, " err"}, {31'd0, err_seen}, {31'd0, v.exp_err});
        if (v.exp_err) begin
            check({nm, " no_mem_en"}, en_cyc, -32'sd1);
            check({nm, " rdata_zero"}, rd_seen, 32'd0);
        end else begin
            check({nm, " en_cycle"}, en_cyc, 32'd1);
            check({nm, " mem_we"}, {28'd0, we_seen}, {28'd0, v.exp_we});
            check({nm, " mem_addr"}, {20'd0, addr_seen}, {20'd0, v.exp_maddr});
            if (v.exp_we != 4'd0) check({nm, " mem_wdata"}, wd_seen, v.exp_wd);
            if (v.chk_rd) check({nm, " rdata"}, rd_seen, v.exp_rd);
        end
    endtask

    vec_t vecs [15];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_order;
        logic [3:0] got_order;
        int         ack_at [4];
        int         n_acks;
        logic       both;
        logic       any_ack;

        for (int a = 0; a < 4096; a++) ram[a] = 32'd0;
        ram[1] = 32'h0050_0093;
        ram[4] = 32'h1122_3344;
        ram[8] = 32'hDEAD_BEEF;

        //        fetch we   size   addr           wdata          err   chk   exp_rd         we       maddr     wd
        vecs[0]  = '{1'b1, 1'b0, 2'b10, 32'h8000_0004, 32'h0,         1'b0, 1'b1, 32'h0050_0093, 4'b0000, 12'd1,    32'h0};
        vecs[1]  = '{1'b0, 1'b1, 2'b00, 32'h8000_0013, 32'h0000_00AB, 1'b0, 1'b0, 32'h0,         4'b1000, 12'd4,    32'hABAB_ABAB};
        vecs[2]  = '{1'b0, 1'b0, 2'b10, 32'h8000_0010, 32'h0,         1'b0, 1'b1, 32'hAB22_3344, 4'b0000, 12'd4,    32'h0};
        vecs[3]  = '{1'b0, 1'b1, 2'b01, 32'h8000_0016, 32'h0000_BEEF, 1'b0, 1'b0, 32'h0,         4'b1100, 12'd5,    32'hBEEF_BEEF};
        vecs[4]  = '{1'b0, 1'b0, 2'b01, 32'h8000_0014, 32'h0,         1'b0, 1'b1, 32'hBEEF_0000, 4'b0000, 12'd5,    32'h0};
        vecs[5]  = '{1'b0, 1'b1, 2'b10, 32'h8000_3FFC, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0,         4'b1111, 12'd4095, 32'hCAFE_F00D};
        vecs[6]  = '{1'b1, 1'b0, 2'b10, 32'h8000_3FFC, 32'h0,         1'b0, 1'b1, 32'hCAFE_F00D, 4'b0000, 12'd4095, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 2'b00, 32'h8000_0001, 32'h0000_005A, 1'b0, 1'b0, 32'h0,         4'b0010, 12'd0,    32'h5A5A_5A5A};
        vecs[8]  = '{1'b0, 1'b1, 2'b01, 32'h8000_0001, 32'h0000_1234, 1'b1, 1'b0, 32'h0,         4'b0000, 12'd0,    32'h0};
        vecs[9]  = '{1'b0, 1'b0, 2'b10, 32'h8000_4000, 32'h0,         1'b1, 1'b0, 32'h0,         4'b0000, 12'd0,    32'h0};
        vecs[10] = '{1'b1, 1'b0, 2'b10, 32'h7FFF_FFFC, 32'h0,         1'b1, 1'b0, 32'h0,         4'b0000, 12'd0,    32'h0};
        vecs[11] = '{1'b0, 1'b0, 2'b10, 32'h8000_0002, 32'h0,         1'b1, 1'b0, 32'h0,         4'b0000, 12'd0,    32'h0};
        vecs[12] = '{1'b0, 1'b0, 2'b11, 32'h8000_0000, 32'h0,         1'b1, 1'b0, 32'h0,         4'b0000, 12'd0,    32'h0};
        vecs[13] = '{1'b1, 1'b0, 2'b10, 32'h8000_0002, 32'h0,         1'b1, 1'b0, 32'h0,         4'b0000, 12'd0,    32'h0};
        vecs[14] = '{1'b0, 1'b0, 2'b00, 32'h8000_0001, 32'h0,         1'b0, 1'b1, 32'h0000_5A00, 4'b0000, 12'd0,    32'h0};

        i_req = 1'b0; i_addr = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_addr = 32'd0; d_wdata = 32'd0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_held");
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("after_reset");

        for (int v = 0; v < 15; v++) run_vec(v, vecs[v]);

        // Reset landing in the ACCESS cycle of a store.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 32'h8000_0020; d_wdata = 32'h1234_5678;
        @(negedge clk);
        check("midrst mem_en_before", {31'd0, mem_en}, 32'd1);
        check("midrst mem_addr_before", {20'd0, mem_addr}, 32'd8);
        reset = 1'b1;
        #1;
        check_idle_outputs("midrst async");
        d_req = 1'b0;
        any_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            any_ack = any_ack | i_ack | d_ack;
        end
        reset = 1'b0;
        #1;
        check_idle_outputs("midrst released");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            any_ack = any_ack | i_ack | d_ack;
        end
        check("midrst no_ack", {31'd0, any_ack}, 32'd0);
        check("midrst ram_unwritten", ram[8], 32'hDEAD_BEEF);
        run_vec(100, vecs[0]);

        // Contention, both requests held over four grants.
`ifdef MEM_ARB_RR_EN
        exp_order = 4'b0101;
`else
        exp_order = 4'b1111;
`endif
        got_order = 4'b0000; n_acks = 0; both = 1'b0;
        for (int j = 0; j < 4; j++) ack_at[j] = -1;
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h8000_0004;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h8000_0010;
        for (int k = 1; k <= 30 && n_acks < 4; k++) begin
            @(negedge clk);
            if (i_ack && d_ack) both = 1'b1;
            if (d_ack) begin
                check($sformatf("contend d_rdata %0d", n_acks), d_rdata, 32'hAB22_3344);
                got_order[n_acks] = 1'b1; ack_at[n_acks] = k; n_acks++;
            end else if (i_ack) begin
                check($sformatf("contend i_rdata %0d", n_acks), i_rdata, 32'h0050_0093);
                got_order[n_acks] = 1'b0; ack_at[n_acks] = k; n_acks++;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        check("contend ack_count", n_acks, 32'd4);
        check("contend dual_ack", {31'd0, both}, 32'd0);
        for (int j = 0; j < 4; j++) begin
            check($sformatf("contend grant %0d is_data", j), {31'd0, got_order[j]}, {31'd0, exp_order[j]});
            check($sformatf("contend ack_cycle %0d", j), ack_at[j], 2 + 3 * j);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
